// File: rtl/updown_btn_conditioner_if.sv
// Pin-side bundle between the board inputs and the up/down counter.
// master: drives the raw pins and observes the clean outputs.
// slave : the conditioner itself.
interface updown_btn_conditioner_if;
  logic btn_dir_raw;
  logic btn_step_raw;
  logic dir;
  logic step;
  logic dir_chg;

  modport master (
    output btn_dir_raw,
    output btn_step_raw,
    input  dir,
    input  step,
    input  dir_chg
  );

  modport slave (
    input  btn_dir_raw,
    input  btn_step_raw,
    output dir,
    output step,
    output dir_chg
  );
endinterface

// File: rtl/updown_btn_conditioner.sv
// Input stage for the 4-bit up/down counter: synchronises and debounces the
// raw direction switch and step button, and turns the debounced step level
// into single-cycle step enables with optional auto-repeat.
//
// Step FSM states:
//   state | meaning
//   IDLE  | button released, waiting for a debounced rising edge
//   DELAY | first pulse issued, timing the initial repeat delay
//   RPT   | auto-repeating, one pulse every RPT_PER cycles while held
module updown_btn_conditioner #(
  parameter int DB_LIMIT = 1000000,
  parameter int DB_W     = 20,
  parameter int AUTO_RPT = 1,
  parameter int RPT_DLY  = 50000000,
  parameter int RPT_PER  = 10000000,
  parameter int RPT_W    = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  updown_btn_conditioner_if.slave   btn
);

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_LIMIT - 1);
  localparam logic [RPT_W-1:0] DLY_MAX = RPT_W'(RPT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_MAX = RPT_W'(RPT_PER - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} state_t;

  // Bit 0 carries the direction switch, bit 1 the step button.
  logic [1:0]      s1_q, s2_q;
  logic [1:0]      stable_q, stable_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  logic            dir_d1_q;
  logic            dir_chg_q;

  state_t          state_q;
  logic [RPT_W-1:0] tmr_q;
  logic            step_q;
  logic            stp_prev_q;
  logic            stp;

  assign stp = stable_q[1];

  // Debounce next-state: a level is accepted only after DB_LIMIT stable samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Two-flop synchronisers and debounce state for both inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= {btn.btn_step_raw, btn.btn_dir_raw};
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Registered change pulse for the debounced direction, one cycle after dir moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_d1_q  <= 1'b0;
      dir_chg_q <= 1'b0;
    end else begin
      dir_d1_q  <= stable_q[0];
      dir_chg_q <= stable_q[0] ^ dir_d1_q;
    end
  end

  // Step FSM with registered pulse output; a release always beats a pending repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      step_q     <= 1'b0;
      stp_prev_q <= 1'b0;
    end else begin
      stp_prev_q <= stp;
      step_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stp && !stp_prev_q) begin
            step_q  <= 1'b1;
            tmr_q   <= '0;
            state_q <= DELAY;
          end
        end
        DELAY: begin
          if (!stp) begin
            state_q <= IDLE;
          end else if ((AUTO_RPT != 0) && (tmr_q == DLY_MAX)) begin
            step_q  <= 1'b1;
            tmr_q   <= '0;
            state_q <= RPT;
          end else if (tmr_q != DLY_MAX) begin
            // Without auto-repeat the timer parks at its limit instead of wrapping.
            tmr_q <= tmr_q + RPT_W'(1);
          end
        end
        RPT: begin
          if (!stp) begin
            state_q <= IDLE;
          end else if (tmr_q == PER_MAX) begin
            step_q <= 1'b1;
            tmr_q  <= '0;
          end else begin
            tmr_q <= tmr_q + RPT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign btn.dir     = stable_q[0];
  assign btn.step    = step_q;
  assign btn.dir_chg = dir_chg_q;

endmodule

// File: tb/tb_updown_btn_conditioner.sv
// Directed bench for updown_btn_conditioner: one auto-repeat instance and one
// single-step instance share the same raw stimulus.
module tb_updown_btn_conditioner;

  typedef int iq_t[$];

  typedef struct {
    logic dr;
    logic sr;
    logic e_dir;
    logic e_step;
    logic e_chg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dir_raw = 1'b1;
  logic step_raw = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  iq_t  p1, p0, c1;
  vec_t vt[$];

  updown_btn_conditioner_if ifc1 ();
  updown_btn_conditioner_if ifc0 ();

  assign ifc1.btn_dir_raw  = dir_raw;
  assign ifc1.btn_step_raw = step_raw;
  assign ifc0.btn_dir_raw  = dir_raw;
  assign ifc0.btn_step_raw = step_raw;

  updown_btn_conditioner #(
    .DB_LIMIT(4), .DB_W(3), .AUTO_RPT(1), .RPT_DLY(10), .RPT_PER(3), .RPT_W(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn(ifc1.slave)
  );

  updown_btn_conditioner #(
    .DB_LIMIT(4), .DB_W(3), .AUTO_RPT(0), .RPT_DLY(10), .RPT_PER(3), .RPT_W(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn(ifc0.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge index after which each pulse was seen.
  always @(negedge clk) begin
    if (ifc1.step === 1'b1) p1.push_back(cyc);
    if (ifc0.step === 1'b1) p0.push_back(cyc);
    if (ifc1.dir_chg === 1'b1) c1.push_back(cyc);
  end

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_list(input string name, input iq_t got, input iq_t exp);
    chk_int({name, ".count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk_int($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  task automatic add_n(input int n, input logic dr, input logic sr,
                       input logic ed, input logic es, input logic ec);
    vec_t v;
    v.dr = dr; v.sr = sr; v.e_dir = ed; v.e_step = es; v.e_chg = ec;
    repeat (n) vt.push_back(v);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_outputs_low(input string tag);
    chk_bit({tag, ".dir1"}, ifc1.dir, 1'b0);
    chk_bit({tag, ".step1"}, ifc1.step, 1'b0);
    chk_bit({tag, ".chg1"}, ifc1.dir_chg, 1'b0);
    chk_bit({tag, ".step0"}, ifc0.step, 1'b0);
    chk_int({tag, ".state1"}, int'(dut1.state_q), 0);
    chk_int({tag, ".state0"}, int'(dut0.state_q), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, p, q, s, rr;
    iq_t e1, e0, ec;

    // Per-cycle vectors; entry i is checked after the (i+1)th edge of its level.
    // Direction rise, accepted on edge 6, change pulse on edge 7.
    add_n(5, 1, 0, 0, 0, 0);
    add_n(1, 1, 0, 1, 0, 0);
    add_n(1, 1, 0, 1, 0, 1);
    add_n(1, 1, 0, 1, 0, 0);
    // Three-cycle glitch low is rejected.
    add_n(3, 0, 0, 1, 0, 0);
    add_n(5, 1, 0, 1, 0, 0);
    // Direction fall.
    add_n(5, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 0, 0, 0);
    add_n(1, 0, 0, 0, 0, 1);
    add_n(1, 0, 0, 0, 0, 0);
    // Shortest accepted pulse: four raw cycles high, then the fall follows.
    add_n(4, 1, 0, 0, 0, 0);
    add_n(1, 0, 0, 0, 0, 0);
    add_n(1, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 1, 0, 1);
    add_n(2, 0, 0, 1, 0, 0);
    add_n(1, 0, 0, 0, 0, 0);
    add_n(1, 0, 0, 0, 0, 1);
    add_n(1, 0, 0, 0, 0, 0);
    // Short step press (3 cycles) never produces a step.
    add_n(3, 0, 1, 0, 0, 0);
    add_n(8, 0, 0, 0, 0, 0);

    // Reset held with raw inputs high.
    repeat (4) @(negedge clk);
    chk_outputs_low("reset_hold");
    dir_raw = 1'b0;
    step_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < vt.size(); i++) begin
      dir_raw = vt[i].dr;
      step_raw = vt[i].sr;
      @(negedge clk);
      chk_bit($sformatf("vec%0d.dir", i), ifc1.dir, vt[i].e_dir);
      chk_bit($sformatf("vec%0d.step", i), ifc1.step, vt[i].e_step);
      chk_bit($sformatf("vec%0d.chg", i), ifc1.dir_chg, vt[i].e_chg);
      chk_bit($sformatf("vec%0d.step0", i), ifc0.step, vt[i].e_step);
    end
    repeat (4) @(negedge clk);

    // Bouncing step button, then a clean hold.
    p1 = {}; p0 = {}; c1 = {};
    b = cyc;
    for (int k = 0; k < 12; k++) begin
      step_raw = ((k % 4) < 2);
      @(negedge clk);
    end
    step_raw = 1'b1;
    wait_to(b + 21);
    step_raw = 1'b0;
    wait_to(b + 40);
    e1 = {b + 19};
    check_list("bounce.step1", p1, e1);
    check_list("bounce.step0", p0, e1);

    // Auto-repeat with a direction change while in RPT, release beats repeat.
    p1 = {}; p0 = {}; c1 = {};
    p = cyc + 7;
    step_raw = 1'b1;
    wait_to(p + 15);
    dir_raw = 1'b1;
    wait_to(p + 20);
    chk_bit("auto.dir_before", ifc1.dir, 1'b0);
    wait_to(p + 21);
    chk_bit("auto.dir_after", ifc1.dir, 1'b1);
    wait_to(p + 33);
    step_raw = 1'b0;
    wait_to(p + 60);
    e1 = {p};
    for (int t = p + 10; t <= p + 37; t += 3) e1.push_back(t);
    e0 = {p};
    ec = {p + 22};
    check_list("auto.step1", p1, e1);
    check_list("auto.step0", p0, e0);
    check_list("auto.dir_chg", c1, ec);
    chk_int("auto.state1", int'(dut1.state_q), 0);
    chk_int("auto.state0", int'(dut0.state_q), 0);

    // Second press: repeat fires on the edge where the debounced fall lands.
    p1 = {}; p0 = {}; c1 = {};
    q = cyc;
    step_raw = 1'b1;
    wait_to(q + 20);
    step_raw = 1'b0;
    wait_to(q + 45);
    e1 = {q + 7, q + 17, q + 20, q + 23, q + 26};
    e0 = {q + 7};
    check_list("press2.step1", p1, e1);
    check_list("press2.step0", p0, e0);

    // Reset asserted while a repeat pulse is on the output.
    s = cyc;
    step_raw = 1'b1;
    wait_to(s + 20);
    chk_bit("midrst.pre_step", ifc1.step, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_outputs_low("midrst");
    p1 = {}; p0 = {}; c1 = {};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rr = cyc;
    wait_to(rr + 8);
    step_raw = 1'b0;
    wait_to(rr + 30);
    e1 = {rr + 7};
    check_list("postrst.step1", p1, e1);
    check_list("postrst.step0", p0, e1);
    check_list("postrst.dir_chg", c1, e1);
    chk_bit("postrst.dir", ifc1.dir, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
